// File: rtl/btn_pulse_gen.sv
// Keypad front end: synchronizes and debounces three code buttons plus check into single-cycle
// press pulses. Define BTN_SIM_ERR_EN to reject simultaneous code presses and count them.
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int N_SYNC          = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_raw,
    input  logic       check_raw,
    output logic       b1,
    output logic       b2,
    output logic       b3,
    output logic       check,
    output logic       sim_err,
    output logic [7:0] err_cnt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    logic [3:0] w_raw;
    logic [3:0] w_cand;

    assign w_raw = {check_raw, btn_raw};

    // Channels come out of reset in PRESSED so a button held across reset never pulses.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [N_SYNC-1:0] r_sync;
            logic              w_s;
            state_t            r_state;
            state_t            w_state_next;
            logic [CW-1:0]     r_cnt;
            logic [CW-1:0]     w_cnt_next;
            logic              w_event;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync  <= '0;
                    r_state <= ST_PRESSED;
                    r_cnt   <= '0;
                end else begin
                    r_sync  <= {r_sync[N_SYNC-2:0], w_raw[gi]};
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            assign w_s = r_sync[N_SYNC-1];

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_event      = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            w_state_next = ST_PRESS_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_s) begin
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_MAX) begin
                            w_state_next = ST_PRESSED;
                            w_event      = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_s) begin
                            w_state_next = ST_RELEASE_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_s) begin
                            w_state_next = ST_PRESSED;
                        end else if (r_cnt == CNT_MAX) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                    default: w_state_next = ST_PRESSED;
                endcase
            end

            assign w_cand[gi] = w_event;
        end
    endgenerate

    logic [2:0] w_code_pulse;
    logic [2:0] r_code;
    logic       r_check;

`ifdef BTN_SIM_ERR_EN
    logic       w_multi;
    logic       r_sim_err;
    logic [7:0] r_err_cnt;

    assign w_multi = (w_cand[0] & w_cand[1]) | (w_cand[0] & w_cand[2]) | (w_cand[1] & w_cand[2]);
    assign w_code_pulse = w_multi ? 3'b000 : w_cand[2:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sim_err <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_sim_err <= w_multi;
            if (w_multi && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign sim_err = r_sim_err;
    assign err_cnt = r_err_cnt;
`else
    // Lowest-index candidate wins; the rest are dropped without trace.
    always_comb begin
        w_code_pulse = 3'b000;
        if (w_cand[0]) begin
            w_code_pulse = 3'b001;
        end else if (w_cand[1]) begin
            w_code_pulse = 3'b010;
        end else if (w_cand[2]) begin
            w_code_pulse = 3'b100;
        end
    end

    assign sim_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code  <= 3'b000;
            r_check <= 1'b0;
        end else begin
            r_code  <= w_code_pulse;
            r_check <= w_cand[3];
        end
    end

    assign b1    = r_code[0];
    assign b2    = r_code[1];
    assign b3    = r_code[2];
    assign check = r_check;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: directed scenarios plus random bounce, each cycle
// compared against a run-length debounce model of the raw inputs.
module tb_btn_pulse_gen;

    localparam int DEB = 4;
    localparam int NS  = 2;
    localparam int LAT = NS + DEB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn_raw = 3'b000;
    logic       check_raw = 1'b0;
    logic       b1, b2, b3, check, sim_err;
    logic [7:0] err_cnt;
    logic [4:0] obs;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .N_SYNC         (NS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .check_raw(check_raw),
        .b1       (b1),
        .b2       (b2),
        .b3       (b3),
        .check    (check),
        .sim_err  (sim_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {sim_err, check, b3, b2, b1};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: synced level = raw delayed NS edges (zero since reset); a channel flips its
    // debounced level after DEB+1 consecutive synced samples disagreeing with it.
    logic [3:0] m_hist[$];
    logic [3:0] m_level = 4'b1111;
    int         m_run[4];
    logic [4:0] exp_out = 5'b0;
    int         exp_cnt = 0;

    task automatic step();
        logic [3:0] raw;
        logic [3:0] s;
        logic [3:0] cand;
        logic [2:0] code;
        logic       err;
        int         n;
        raw = {check_raw, btn_raw};
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_hist.delete();
            m_level = 4'b1111;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
            exp_out = 5'b0;
            exp_cnt = 0;
        end else begin
            s = (m_hist.size() >= NS) ? m_hist[m_hist.size() - NS] : 4'b0000;
            m_hist.push_back(raw);
            if (m_hist.size() > NS) void'(m_hist.pop_front());
            cand = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                if (s[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB + 1) begin
                        m_level[c] = s[c];
                        m_run[c]   = 0;
                        cand[c]    = s[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            n    = int'(cand[0]) + int'(cand[1]) + int'(cand[2]);
            code = cand[2:0];
            err  = 1'b0;
`ifdef BTN_SIM_ERR_EN
            if (n >= 2) begin
                code = 3'b000;
                err  = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
`else
            if (n >= 2) begin
                if (cand[0]) code = 3'b001;
                else         code = 3'b010;
            end
`endif
            exp_out = {err, cand[3], code};
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_raw = 3'b000;
        check_raw = 1'b0;
        step();
        step();
        checks++;
        if (obs !== 5'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got out=%b cnt=%0d want out=00000 cnt=0", obs, err_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_press();
        int t_raise = 0, t_pulse = -1, n_b1 = 0, n_other = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL single_idle cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        btn_raw[0] = 1'b1;
        t_raise = cyc + 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (b1) begin n_b1++; t_pulse = cyc; end
            if (b2 || b3 || check) n_other++;
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL single_hold cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        checks++;
        if (n_b1 != 1 || n_other != 0) begin
            failures++;
            $display("FAIL single_count got b1=%0d other=%0d want b1=1 other=0", n_b1, n_other);
        end
        checks++;
        if (t_pulse - t_raise != LAT) begin
            failures++;
            $display("FAIL single_latency got=%0d want=%0d", t_pulse - t_raise, LAT);
        end
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_bounce();
        logic [0:15] press_seq;
        logic [0:15] rel_seq;
        int t_raise = 0, t_pulse = -1, n_b2 = 0;
        press_seq = 16'b1010_1111_1111_1111;
        rel_seq   = 16'b0101_0000_0000_0000;
        for (int i = 0; i < 16; i++) begin
            btn_raw[1] = press_seq[i];
            if (i == 4) t_raise = cyc + 1;
            step();
            if (b2) begin n_b2++; t_pulse = cyc; end
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL bounce_press cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        for (int i = 0; i < 16; i++) begin
            btn_raw[1] = rel_seq[i];
            step();
            if (b2) n_b2++;
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL bounce_release cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        checks++;
        if (n_b2 != 1 || t_pulse - t_raise != LAT) begin
            failures++;
            $display("FAIL bounce_b2 got pulses=%0d lat=%0d want pulses=1 lat=%0d", n_b2, t_pulse - t_raise, LAT);
        end
    endtask

    task automatic test_held_through_reset();
        int n_held = 0, n_after = 0;
        btn_raw[2] = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i == 15) btn_raw[2] = 1'b0;
            if (i == 25) btn_raw[2] = 1'b1;
            if (i == 35) btn_raw[2] = 1'b0;
            step();
            if (b3 && i < 25) n_held++;
            if (b3 && i >= 25) n_after++;
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL held_reset cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        checks++;
        if (n_held != 0 || n_after != 1) begin
            failures++;
            $display("FAIL held_reset_b3 got held=%0d after=%0d want held=0 after=1", n_held, n_after);
        end
    endtask

    task automatic test_simultaneous();
        int n_b1 = 0, n_b2 = 0, n_err = 0;
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 18; i++) begin
                btn_raw = (i < 9) ? 3'b011 : 3'b000;
                step();
                if (b1) n_b1++;
                if (b2) n_b2++;
                if (sim_err) n_err++;
                checks++;
                if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                    failures++;
                    $display("FAIL simul cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
                end
            end
            if (r == 0) begin
                checks++;
`ifdef BTN_SIM_ERR_EN
                if (err_cnt !== 8'd1 || n_b1 != 0 || n_b2 != 0 || n_err != 1) begin
`else
                if (err_cnt !== 8'd0 || n_b1 != 1 || n_b2 != 0 || n_err != 0) begin
`endif
                    failures++;
                    $display("FAIL simul_first got cnt=%0d b1=%0d b2=%0d err=%0d", err_cnt, n_b1, n_b2, n_err);
                end
            end
        end
        checks++;
`ifdef BTN_SIM_ERR_EN
        if (err_cnt !== 8'd255 || n_err != 300 || n_b1 != 0 || n_b2 != 0) begin
`else
        if (err_cnt !== 8'd0 || n_err != 0 || n_b1 != 300 || n_b2 != 0) begin
`endif
            failures++;
            $display("FAIL simul_total got cnt=%0d err=%0d b1=%0d b2=%0d", err_cnt, n_err, n_b1, n_b2);
        end
    endtask

    task automatic test_check_with_code();
        int t_b1 = -1, t_chk = -2, n_b1 = 0, n_chk = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw[0] = (i < 10);
            check_raw  = (i < 10);
            step();
            if (b1) begin n_b1++; t_b1 = cyc; end
            if (check) begin n_chk++; t_chk = cyc; end
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL check_code cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        checks++;
        if (n_b1 != 1 || n_chk != 1 || t_b1 != t_chk) begin
            failures++;
            $display("FAIL check_same_cycle got b1=%0d@%0d check=%0d@%0d want one each same cycle",
                     n_b1, t_b1, n_chk, t_chk);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int n_b1 = 0;
        int order[$];
        btn_raw = 3'b001;
        check_raw = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (obs !== 5'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midreset_outputs got out=%b cnt=%0d want out=00000 cnt=0", obs, err_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 15) btn_raw = 3'b000;
            step();
            if (b1) n_b1++;
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL midreset cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        checks++;
        if (n_b1 != 0) begin
            failures++;
            $display("FAIL midreset_nopulse got b1=%0d want 0", n_b1);
        end
        for (int ch = 0; ch < 4; ch++) begin
            for (int i = 0; i < 18; i++) begin
                if (ch < 3) btn_raw[ch] = (i < 9);
                else        check_raw   = (i < 9);
                step();
                if (b1) order.push_back(0);
                if (b2) order.push_back(1);
                if (b3) order.push_back(2);
                if (check) order.push_back(3);
                checks++;
                if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                    failures++;
                    $display("FAIL sequence cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
                end
            end
        end
        checks++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
            failures++;
            $display("FAIL sequence_order got %0d pulses want b1,b2,b3,check once each", order.size());
        end
    endtask

    task automatic test_random();
        logic [3:0] raw;
        raw = 4'b0000;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            end
            btn_raw   = raw[2:0];
            check_raw = raw[3];
            rst_n     = ($urandom_range(0, 399) != 0);
            step();
            checks++;
            if (obs !== exp_out || err_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b/%0d want=%b/%0d", cyc, obs, err_cnt, exp_out, exp_cnt);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) m_run[c] = 0;
        test_reset();
        test_single_press();
        test_bounce();
        test_held_through_reset();
        test_simultaneous();
        test_check_with_code();
        test_reset_mid_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
